// File: rtl/layer_compositor_pkg.sv
// Shared colour constants, default palette and width helper for the layer compositor.
// Colours are 4:4:4 RGB packed as {R, G, B}.
package layer_compositor_pkg;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t COLOR_BLACK   = 12'h000;
    localparam rgb444_t COLOR_YELLOW  = 12'hFF0;
    localparam rgb444_t COLOR_CYAN    = 12'h0FF;
    localparam rgb444_t COLOR_MAGENTA = 12'hF0F;
    localparam rgb444_t COLOR_BLUE    = 12'h00F;
    localparam rgb444_t COLOR_GREEN   = 12'h0F0;
    localparam rgb444_t COLOR_RED     = 12'hF00;
    localparam rgb444_t COLOR_WHITE   = 12'hFFF;

    // Entry [i] is the reset colour of palette index i in every layer.
    localparam logic [7:0][11:0] DEFAULT_PALETTE = {
        COLOR_WHITE, COLOR_RED, COLOR_GREEN, COLOR_BLUE,
        COLOR_MAGENTA, COLOR_CYAN, COLOR_YELLOW, COLOR_BLACK
    };

    function automatic rgb444_t default_color(input int unsigned idx);
        logic [2:0] sel;
        if (idx > 7) begin
            return COLOR_BLACK;
        end
        sel = idx[2:0];
        return DEFAULT_PALETTE[sel];
    endfunction

    // Ceiling log2, never less than 1 so derived vectors stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/layer_compositor_palette.sv
// layer_palette: per-layer palette register file with write decode and the
// registered stage-3 read that produces the output colour.
module layer_palette
    import layer_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned RGB_W      = 12,
    parameter int unsigned SEL_W      = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_wr_layer,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [RGB_W-1:0] i_wr_rgb,
    input  logic             i_rd_en,
    input  logic [SEL_W-1:0] i_rd_layer,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [RGB_W-1:0] o_rgb
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [RGB_W-1:0] r_pal [NUM_LAYERS][DEPTH];
    logic [RGB_W-1:0] r_rgb;
    logic [RGB_W-1:0] w_rd_rgb;

    // Out-of-range layer selects match no row, so those writes fall away.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    r_pal[l][e] <= RGB_W'(default_color(e));
                end
            end
        end else begin
            for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (i_we && i_wr_layer == SEL_W'(l) && i_wr_idx == IDX_W'(e)) begin
                        r_pal[l][e] <= i_wr_rgb;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_rgb = '0;
        for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
            if (i_rd_layer == SEL_W'(l)) begin
                w_rd_rgb = r_pal[l][i_rd_idx];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= i_rd_en ? w_rd_rgb : '0;
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: three-stage fixed-priority merge of indexed-colour layers with
// per-layer enable, frame-based blinking and a run-time writable palette.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned RGB_W        = 12,
    parameter int unsigned COORD_W      = 11,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BLINK_FRAMES = 30,
    // One spare code so that out-of-range layer selects can be expressed and ignored.
    localparam int unsigned SEL_W       = clog2(NUM_LAYERS + 1)
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        iPixelValid,
    input  logic [COORD_W-1:0]          iRow,
    input  logic [COORD_W-1:0]          iCol,
    input  logic [NUM_LAYERS*IDX_W-1:0] iLayerIdx,
    input  logic [NUM_LAYERS-1:0]       iLayerEnable,
    input  logic [NUM_LAYERS-1:0]       iLayerBlink,
    input  logic                        iPalWe,
    input  logic [SEL_W-1:0]            iPalLayer,
    input  logic [IDX_W-1:0]            iPalIdx,
    input  logic [RGB_W-1:0]            iPalRgb,
    output logic [RGB_W-1:0]            oRGB,
    output logic                        oPixelValid,
    output logic                        oBlinkPhase
);

    localparam int unsigned CNT_W = clog2(BLINK_FRAMES);

    logic                        r_s1_valid;
    logic                        r_s1_active;
    logic                        r_s1_frame_start;
    logic [NUM_LAYERS*IDX_W-1:0] r_s1_idx;
    logic [NUM_LAYERS-1:0]       r_s1_en;
    logic [NUM_LAYERS-1:0]       r_s1_blink;

    logic                        r_s2_valid;
    logic                        r_s2_active;
    logic                        r_s2_hit;
    logic [SEL_W-1:0]            r_s2_layer;
    logic [IDX_W-1:0]            r_s2_idx;

    logic                        r_s3_valid;
    logic [CNT_W-1:0]            r_frame_cnt;
    logic                        r_phase;

    logic                        w_frame_start;
    logic                        w_active;
    logic                        w_hit;
    logic [SEL_W-1:0]            w_layer;
    logic [IDX_W-1:0]            w_idx;
    logic [IDX_W-1:0]            w_lidx;

    assign w_frame_start = iPixelValid && (iRow == '0) && (iCol == '0);
    assign w_active      = (iCol < COORD_W'(H_ACTIVE)) && (iRow < COORD_W'(V_ACTIVE));

    // Stage 1: capture the pixel and its layer controls.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid       <= 1'b0;
            r_s1_active      <= 1'b0;
            r_s1_frame_start <= 1'b0;
            r_s1_idx         <= '0;
            r_s1_en          <= '0;
            r_s1_blink       <= '0;
        end else begin
            r_s1_valid       <= iPixelValid;
            r_s1_active      <= w_active;
            r_s1_frame_start <= w_frame_start;
            r_s1_idx         <= iLayerIdx;
            r_s1_en          <= iLayerEnable;
            r_s1_blink       <= iLayerBlink;
        end
    end

    // Ascending scan: the last visible layer seen is the highest-priority one.
    always_comb begin
        w_hit   = 1'b0;
        w_layer = '0;
        w_idx   = '0;
        w_lidx  = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            w_lidx = r_s1_idx[k*IDX_W +: IDX_W];
            if (r_s1_en[k] && (w_lidx != '0) && !(r_s1_blink[k] && r_phase)) begin
                w_hit   = 1'b1;
                w_layer = SEL_W'(k);
                w_idx   = w_lidx;
            end
        end
    end

    // Stage 2: registered priority result.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_active <= 1'b0;
            r_s2_hit    <= 1'b0;
            r_s2_layer  <= '0;
            r_s2_idx    <= '0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_active <= r_s1_active;
            r_s2_hit    <= w_hit;
            r_s2_layer  <= w_layer;
            r_s2_idx    <= w_idx;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s3_valid <= 1'b0;
        end else begin
            r_s3_valid <= r_s2_valid;
        end
    end

    // Phase flips as the frame-start pixel leaves stage 1, so that pixel keeps
    // the old phase and its successor sees the new one.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_s1_frame_start) begin
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    layer_palette #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W),
        .RGB_W      (RGB_W),
        .SEL_W      (SEL_W)
    ) u_palette (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .i_we       (iPalWe),
        .i_wr_layer (iPalLayer),
        .i_wr_idx   (iPalIdx),
        .i_wr_rgb   (iPalRgb),
        .i_rd_en    (r_s2_valid && r_s2_active && r_s2_hit),
        .i_rd_layer (r_s2_layer),
        .i_rd_idx   (r_s2_idx),
        .o_rgb      (oRGB)
    );

    assign oPixelValid = r_s3_valid;
    assign oBlinkPhase = r_phase;

endmodule
